uart_wrapper: RTL and testbench

Copter-side endpoint of the wireless command link. Receives 3-byte command frames (opcode, data high byte, data low byte) over a 8N1 UART and presents them to the command FSM as one `cmd`/`data` pair with a ready flag. It also serialises 1-byte responses (positive ack, battery level) back to the ground-side `CommMaster`. It sits in `QuadCopter` between the `RX`/`TX` pins and the command decoder.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_wrapper_if.sv | 24 ++
 rtl/uart_wrapper_uart.sv | 192 +++++++++++++++++++
 rtl/uart_wrapper.sv | 92 +++++++++
 tb/tb_uart_wrapper.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the wireless command-link UART endpoint.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    FRM_B0,
    FRM_B1,
    FRM_B2
  } frame_state_t;

  localparam logic [7:0]  RESP_ACK    = 8'hA5;
  localparam int unsigned FRAME_BYTES = 3;

endpackage

// File: rtl/uart_wrapper_if.sv
// Command/response handshake between the UART endpoint and the command decoder.
interface uart_wrapper_if;

  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  // Endpoint side: presents frames, accepts responses.
  modport slave (
    output cmd, data, cmd_rdy, resp_sent,
    input  clr_cmd_rdy, resp, send_resp
  );

  // Decoder side: consumes frames, issues responses.
  modport master (
    input  cmd, data, cmd_rdy, resp_sent,
    output clr_cmd_rdy, resp, send_resp
  );

endinterface

// File: rtl/uart_wrapper_uart.sv
// Byte-level 8N1 transceiver: independent receive and transmit engines.
module uart
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       rx_err,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       tx_done
);

  localparam logic [11:0] BIT_RELOAD  = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_RELOAD = 12'(BAUD_DIV / 2 - 1);

  // ---------------------------------------------------------------- RX
  rx_state_t   rx_state, rx_state_nxt;
  logic        rx_meta, rx_sync, rx_prev;
  logic [11:0] rx_cnt;
  logic [2:0]  rx_bits;
  logic [7:0]  rx_shift;
  logic        rx_fall, rx_tick;
  logic        rx_load_half, rx_load_full, rx_sample, rx_stop_ok, rx_stop_bad;

  assign rx_fall = rx_prev & ~rx_sync;
  assign rx_tick = (rx_cnt == '0);
  assign rx_data = rx_shift;

  // Two-flop synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receive state register.
  always_ff @(posedge clk) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_nxt;
  end

  // Receive next-state and control strobes.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_load_half = 1'b0;
    rx_load_full = 1'b0;
    rx_sample    = 1'b0;
    rx_stop_ok   = 1'b0;
    rx_stop_bad  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_nxt = RX_START;
          rx_load_half = 1'b1;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          if (rx_sync) begin
            rx_state_nxt = RX_IDLE;
          end else begin
            rx_state_nxt = RX_DATA;
            rx_load_full = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_sample    = 1'b1;
          rx_load_full = 1'b1;
          if (rx_bits == 3'd7) rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_state_nxt = RX_IDLE;
          if (rx_sync) rx_stop_ok  = 1'b1;
          else         rx_stop_bad = 1'b1;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // Receive bit timing, bit count and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_rdy   <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_rdy <= rx_stop_ok;
      rx_err <= rx_stop_bad;
      if (rx_load_half)      rx_cnt <= HALF_RELOAD;
      else if (rx_load_full) rx_cnt <= BIT_RELOAD;
      else if (!rx_tick)     rx_cnt <= rx_cnt - 12'd1;
      if (rx_load_half)      rx_bits <= '0;
      else if (rx_sample)    rx_bits <= rx_bits + 3'd1;
      if (rx_sample)         rx_shift <= {rx_sync, rx_shift[7:1]};
    end
  end

  // ---------------------------------------------------------------- TX
  tx_state_t   tx_state, tx_state_nxt;
  logic [11:0] tx_cnt;
  logic [2:0]  tx_bits;
  logic [9:0]  tx_shift;
  logic        tx_tick, tx_load, tx_step, tx_finish;

  assign tx_tick = (tx_cnt == '0);
  // The whole frame {stop, data, start} is shifted out; bit 0 is the line.
  assign TX      = tx_shift[0];

  // Transmit state register.
  always_ff @(posedge clk) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_state_nxt;
  end

  // Transmit next-state and control strobes; requests while busy are dropped.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_load      = 1'b0;
    tx_step      = 1'b0;
    tx_finish    = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (trmt) begin
          tx_state_nxt = TX_START;
          tx_load      = 1'b1;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_step      = 1'b1;
          tx_state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_step = 1'b1;
          if (tx_bits == 3'd7) tx_state_nxt = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          tx_step      = 1'b1;
          tx_finish    = 1'b1;
          tx_state_nxt = TX_IDLE;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // Transmit bit timing, shift register and completion flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '1;
      tx_done  <= 1'b0;
    end else begin
      if (tx_load) begin
        tx_cnt   <= BIT_RELOAD;
        tx_bits  <= '0;
        tx_shift <= {1'b1, tx_data, 1'b0};
      end else if (tx_state != TX_IDLE) begin
        tx_cnt <= tx_tick ? BIT_RELOAD : tx_cnt - 12'd1;
        if (tx_step) tx_shift <= {1'b1, tx_shift[9:1]};
        if (tx_step && tx_state == TX_DATA) tx_bits <= tx_bits + 3'd1;
      end
      if (tx_load)        tx_done <= 1'b0;
      else if (tx_finish) tx_done <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_wrapper.sv
// Copter-side command-link endpoint: assembles 3-byte command frames and
// sends 1-byte responses over an 8N1 UART.
module uart_wrapper
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           RX,
  output logic           TX,
  uart_wrapper_if.slave  cmd_if
);

  logic [7:0]   rx_data;
  logic         rx_rdy, rx_err, tx_done;
  frame_state_t frm_state, frm_nxt;
  logic [7:0]   cmd_shadow, hi_shadow;
  logic [7:0]   cmd_q;
  logic [15:0]  data_q;
  logic         cmd_rdy_q;
  logic         frame_done, frame_first;

  uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .TX      (TX),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .rx_err  (rx_err),
    .tx_data (cmd_if.resp),
    .trmt    (cmd_if.send_resp),
    .tx_done (tx_done)
  );

  assign cmd_if.cmd       = cmd_q;
  assign cmd_if.data      = data_q;
  assign cmd_if.cmd_rdy   = cmd_rdy_q;
  assign cmd_if.resp_sent = tx_done;

  // Frame assembler state register.
  always_ff @(posedge clk) begin
    if (!rst_n) frm_state <= FRM_B0;
    else        frm_state <= frm_nxt;
  end

  // Frame assembler next state; a framing error restarts at byte 0.
  always_comb begin
    frm_nxt     = frm_state;
    frame_done  = 1'b0;
    frame_first = 1'b0;
    if (rx_err) begin
      frm_nxt = FRM_B0;
    end else if (rx_rdy) begin
      case (frm_state)
        FRM_B0: begin
          frame_first = 1'b1;
          frm_nxt     = FRM_B1;
        end
        FRM_B1: frm_nxt = FRM_B2;
        FRM_B2: begin
          frame_done = 1'b1;
          frm_nxt    = FRM_B0;
        end
        default: frm_nxt = FRM_B0;
      endcase
    end
  end

  // Shadow bytes and output registers; outputs move only on a whole frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_shadow <= '0;
      hi_shadow  <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      cmd_rdy_q  <= 1'b0;
    end else begin
      if (rx_rdy && frm_state == FRM_B0) cmd_shadow <= rx_data;
      if (rx_rdy && frm_state == FRM_B1) hi_shadow  <= rx_data;
      if (frame_done) begin
        cmd_q  <= cmd_shadow;
        data_q <= {hi_shadow, rx_data};
      end
      // Completion takes priority over an acknowledge in the same cycle.
      if (frame_done)                               cmd_rdy_q <= 1'b1;
      else if (cmd_if.clr_cmd_rdy || frame_first)   cmd_rdy_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_wrapper.sv
// Directed self-checking bench for uart_wrapper at BAUD_DIV = 16.
module tb_uart_wrapper;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic RX;
  logic TX;
  int   checks = 0;
  int   errors = 0;
  int   rise;

  uart_wrapper_if bus ();

  uart_wrapper #(.BAUD_DIV(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .TX     (TX),
    .cmd_if (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one 8N1 byte (16 clocks per bit) then 4 idle clocks.
  // rise_at: index of the edge (0 = first edge of the start bit) after which
  // cmd_rdy went 0->1; clr_at pulses clr_cmd_rdy into the following edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                           input int clr_at, output int rise_at);
    logic [9:0] frm;
    logic       prev;
    int         m;
    frm     = {stop_bit, b, 1'b0};
    rise_at = -1;
    m       = 0;
    for (int j = 0; j < 10; j++) begin
      RX = frm[j];
      repeat (16) begin
        prev = bus.cmd_rdy;
        tick();
        if (bus.cmd_rdy === 1'b1 && prev === 1'b0 && rise_at < 0) rise_at = m;
        if (clr_at >= 0) bus.clr_cmd_rdy = (m == clr_at);
        m++;
      end
    end
    RX = 1'b1;
    repeat (4) tick();
  endtask

  // Issues send_resp for r and checks the line mid-bit against expf[k],
  // plus the resp_sent timing. stray_at injects a busy-time request of C0.
  task automatic tx_byte(input logic [7:0] r, input logic [9:0] expf,
                         input int stray_at, input string tag);
    int k;
    bus.resp      = r;
    bus.send_resp = 1'b1;
    for (int cyc = 1; cyc <= 161; cyc++) begin
      tick();
      bus.send_resp = (cyc == stray_at);
      bus.resp      = (cyc == stray_at) ? 8'hC0 : r;
      if (cyc == 1) check({tag, "_tx_fall"}, TX, 0);
      if (cyc >= 9 && cyc <= 153 && ((cyc - 9) % 16) == 0) begin
        k = (cyc - 9) / 16;
        check($sformatf("%s_bit%0d", tag, k), TX, expf[k]);
      end
      if (cyc == 160) check({tag, "_sent_early"}, bus.resp_sent, 0);
      if (cyc == 161) check({tag, "_sent"}, bus.resp_sent, 1);
    end
  endtask

  initial begin
    RX              = 1'b1;
    rst_n           = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp        = '0;
    bus.send_resp   = 1'b0;
    repeat (3) tick();
    check("rst_tx", TX, 1);
    check("rst_cmd", bus.cmd, 8'h00);
    check("rst_data", bus.data, 16'h0000);
    check("rst_rdy", bus.cmd_rdy, 0);
    check("rst_sent", bus.resp_sent, 0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Frame 02,00,FA with exact cmd_rdy latency, then acknowledge.
    send_byte(8'h02, 1'b1, -1, rise);
    send_byte(8'h00, 1'b1, -1, rise);
    send_byte(8'hFA, 1'b1, -1, rise);
    check("f1_latency", rise, 155);
    check("f1_cmd", bus.cmd, 8'h02);
    check("f1_data", bus.data, 16'h00FA);
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    check("f1_clr", bus.cmd_rdy, 0);

    // Partial frame broken by a framing error never reaches the outputs.
    send_byte(8'h05, 1'b1, -1, rise);
    send_byte(8'h12, 1'b1, -1, rise);
    send_byte(8'h07, 1'b0, -1, rise);
    check("ferr_cmd", bus.cmd, 8'h02);
    check("ferr_data", bus.data, 16'h00FA);
    check("ferr_rdy", bus.cmd_rdy, 0);
    send_byte(8'h07, 1'b1, -1, rise);
    send_byte(8'h00, 1'b1, -1, rise);
    send_byte(8'h00, 1'b1, -1, rise);
    check("f2_cmd", bus.cmd, 8'h07);
    check("f2_data", bus.data, 16'h0000);
    check("f2_rdy", bus.cmd_rdy, 1);

    // Byte 0 clears a pending flag; completion beats a same-cycle clear.
    send_byte(8'h03, 1'b1, -1, rise);
    check("f3_b0_clears", bus.cmd_rdy, 0);
    send_byte(8'hAB, 1'b1, -1, rise);
    send_byte(8'hCD, 1'b1, 154, rise);
    check("f3_latency", rise, 155);
    check("f3_rdy", bus.cmd_rdy, 1);
    check("f3_cmd", bus.cmd, 8'h03);
    check("f3_data", bus.data, 16'hABCD);
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;

    // A5 response with an ignored mid-byte request, then back-to-back 3C.
    tx_byte(RESP_ACK, 10'b11_0100_1010, 40, "ack");
    tx_byte(8'h3C, 10'b10_0111_1000, -1, "b2b");

    // Full duplex: frame 01,00,00 in while A5 goes out.
    fork
      begin
        send_byte(8'h01, 1'b1, -1, rise);
        send_byte(8'h00, 1'b1, -1, rise);
        send_byte(8'h00, 1'b1, -1, rise);
      end
      tx_byte(RESP_ACK, 10'b11_0100_1010, -1, "dup");
    join
    check("dup_cmd", bus.cmd, 8'h01);
    check("dup_data", bus.data, 16'h0000);
    check("dup_rdy", bus.cmd_rdy, 1);

    // Reset in the middle of a frame, a received byte and a transmission.
    send_byte(8'h09, 1'b1, -1, rise);
    send_byte(8'h11, 1'b1, -1, rise);
    bus.resp      = 8'h5A;
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
    check("mid_tx_busy", TX, 0);
    RX = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_tx", TX, 1);
    check("mid_rst_cmd", bus.cmd, 8'h00);
    check("mid_rst_data", bus.data, 16'h0000);
    check("mid_rst_rdy", bus.cmd_rdy, 0);
    check("mid_rst_sent", bus.resp_sent, 0);
    rst_n = 1'b1;
    RX    = 1'b1;
    repeat (4) tick();
    send_byte(8'h06, 1'b1, -1, rise);
    send_byte(8'h00, 1'b1, -1, rise);
    send_byte(8'h00, 1'b1, -1, rise);
    check("post_rst_cmd", bus.cmd, 8'h06);
    check("post_rst_data", bus.data, 16'h0000);
    check("post_rst_rdy", bus.cmd_rdy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
